// File: rtl/sobel_result_framer.sv
// Output framer for the Sobel pipeline: buffers filtered pixels in a FIFO and transmits
// a 4-byte little-endian width/height header followed by width*height pixel bytes.
module sobel_result_framer #(
  parameter int unsigned DataBits  = 8,
  parameter int unsigned FifoDepth = 16
) (
  input  logic                clk_a,
  input  logic                rst,
  input  logic                start_i,
  input  logic [15:0]         width_i,
  input  logic [15:0]         height_i,
  input  logic [DataBits-1:0] pix_data_i,
  input  logic                pix_valid_i,
  input  logic                tx_ready_i,
  output logic [DataBits-1:0] tx_data_o,
  output logic                tx_valid_o,
  output logic                busy_o,
  output logic                overflow_o,
  output logic                done_o
);

  localparam int unsigned AddrW = $clog2(FifoDepth);

  typedef enum logic [1:0] {StIdle, StHdr, StPix, StFin} state_e;

  state_e              state_q, state_d;
  logic [15:0]         w_q, w_d, h_q, h_d;
  logic [31:0]         total_q, total_d, sent_q, sent_d, cap_q, cap_d;
  logic [1:0]          idx_q, idx_d;
  logic [DataBits-1:0] tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, done_q;
  logic [AddrW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DataBits-1:0] mem_q [FifoDepth];

  logic fifo_empty, fifo_full, xfer, last_xfer, pop, capture, push;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign xfer       = tx_valid_q && tx_ready_i;
  assign last_xfer  = xfer && ((sent_q + 32'd1) == total_q);
  // Refill the output register whenever it is free or being emptied, except after the final byte.
  assign pop        = (state_q == StPix) && !fifo_empty && (!tx_valid_q || xfer) && !last_xfer;
  assign capture    = ((state_q == StHdr) || (state_q == StPix)) && pix_valid_i &&
                      (cap_q < total_q);
  assign push       = capture && (!fifo_full || pop);

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    h_d        = h_q;
    total_d    = total_q;
    sent_d     = sent_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q + (AddrW + 1)'(push);
    cap_d      = cap_q + 32'(push);
    overflow_d = overflow_q | (capture && !push);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          w_d        = width_i;
          h_d        = height_i;
          total_d    = 32'(width_i) * 32'(height_i);
          sent_d     = '0;
          cap_d      = '0;
          idx_d      = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          overflow_d = 1'b0;
          tx_data_d  = DataBits'(width_i[7:0]);
          tx_valid_d = 1'b1;
          state_d    = StHdr;
        end
      end
      StHdr: begin
        if (xfer) begin
          idx_d = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: tx_data_d = DataBits'(w_q[15:8]);
            2'd1: tx_data_d = DataBits'(h_q[7:0]);
            2'd2: tx_data_d = DataBits'(h_q[15:8]);
            2'd3: begin
              tx_valid_d = 1'b0;
              state_d    = (total_q == 32'd0) ? StFin : StPix;
            end
          endcase
        end
      end
      StPix: begin
        if (xfer) begin
          sent_d     = sent_q + 32'd1;
          tx_valid_d = 1'b0;
          if (last_xfer) state_d = StFin;
        end
        if (pop) begin
          tx_data_d  = mem_q[rd_ptr_q[AddrW-1:0]];
          tx_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + (AddrW + 1)'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= pix_data_i;
  end

  always_ff @(posedge clk_a) begin
    if (rst) begin
      state_q    <= StIdle;
      w_q        <= '0;
      h_q        <= '0;
      total_q    <= '0;
      sent_q     <= '0;
      cap_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      h_q        <= h_d;
      total_q    <= total_d;
      sent_q     <= sent_d;
      cap_q      <= cap_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StFin);
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_sobel_result_framer.sv
// Bench for sobel_result_framer: directed and randomized frames compared against an expected
// byte stream (header + captured pixels) built from the frame parameters.
module tb_sobel_result_framer;

  localparam int FifoDepth = 16;

  logic       clk_a = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [15:0] width_i = '0, height_i = '0;
  logic [7:0] pix_data_i = '0;
  logic       pix_valid_i = 1'b0;
  logic       tx_ready_i = 1'b0;
  logic [7:0] tx_data_o;
  logic       tx_valid_o, busy_o, overflow_o, done_o;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  bit stall_q = 1'b0;
  logic [7:0] held_q = '0;

  sobel_result_framer #(.DataBits(8), .FifoDepth(FifoDepth)) dut (
    .clk_a      (clk_a),
    .rst        (rst),
    .start_i    (start_i),
    .width_i    (width_i),
    .height_i   (height_i),
    .pix_data_i (pix_data_i),
    .pix_valid_i(pix_valid_i),
    .tx_ready_i (tx_ready_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o),
    .done_o     (done_o)
  );

  always #5 clk_a = ~clk_a;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Collect accepted bytes and enforce that a stalled byte holds steady.
  always @(negedge clk_a) begin
    if (!rst) begin
      if (stall_q) begin
        checks++;
        assert (tx_valid_o === 1'b1 && tx_data_o === held_q) else begin
          failures++;
          $error("FAIL stall_hold observed=%0b/%0h expected=1/%0h", tx_valid_o, tx_data_o, held_q);
        end
      end
      if (tx_valid_o && tx_ready_i) got.push_back(tx_data_o);
      if (done_o) done_cnt++;
    end
    stall_q = tx_valid_o && !tx_ready_i && !rst;
    held_q  = tx_data_o;
  end

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_header(input int w, input int h);
    exp_q.delete();
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(h[7:0]);
    exp_q.push_back(h[15:8]);
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, " byte_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s byte%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic begin_frame(input int w, input int h);
    got.delete();
    done_cnt = 0;
    start_i  = 1'b1;
    width_i  = w[15:0];
    height_i = h[15:0];
    tick();
    start_i  = 1'b0;
  endtask

  // rdy_mode: 0 always, 1 one-in-three, 2 random. pix_mode: 0 every cycle, 1 every 4th, 2 random.
  task automatic run_frame(input string tag, input int w, input int h, input int rdy_mode,
                           input int pix_mode, input int pix_base, input int extra);
    int total, nsent, cyc, budget, pixrx;
    bit done_seen, slot;
    logic [7:0] b;
    total = w * h;
    push_header(w, h);
    begin_frame(w, h);
    chk({tag, " start_busy"}, busy_o, 1);
    chk({tag, " start_valid"}, tx_valid_o, 1);
    nsent = 0;
    cyc = 0;
    done_seen = 0;
    budget = total * 16 + 200;
    while (!done_seen && cyc < budget) begin
      pixrx = (got.size() > 4) ? got.size() - 4 : 0;
      case (rdy_mode)
        0: tx_ready_i = 1'b1;
        1: tx_ready_i = ((cyc % 3) == 0);
        default: tx_ready_i = 1'($urandom_range(0, 1));
      endcase
      case (pix_mode)
        0: slot = 1'b1;
        1: slot = ((cyc % 4) == 0);
        default: slot = ($urandom_range(0, 2) == 0);
      endcase
      pix_valid_i = 1'b0;
      // Only offer a frame pixel when it is guaranteed to find room in the FIFO.
      if (slot && nsent < total + extra && (nsent >= total || nsent - pixrx < FifoDepth)) begin
        b = (pix_base < 0) ? 8'($urandom) : 8'(pix_base + nsent);
        pix_data_i  = b;
        pix_valid_i = 1'b1;
        if (nsent < total) exp_q.push_back(b);
        nsent++;
      end
      tick();
      cyc++;
      if (done_o) done_seen = 1'b1;
    end
    while (nsent < total + extra) begin
      pix_valid_i = 1'b1;
      pix_data_i  = 8'($urandom);
      nsent++;
      tick();
    end
    pix_valid_i = 1'b0;
    tick();
    tick();
    chk({tag, " done_seen"}, done_seen, 1);
    check_stream(tag);
    chk({tag, " overflow"}, overflow_o, 0);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " idle_busy"}, busy_o, 0);
    chk({tag, " idle_valid"}, tx_valid_o, 0);
  endtask

  initial begin
    bit done_seen;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset tx_data", tx_data_o, 0);
    chk("reset tx_valid", tx_valid_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset overflow", overflow_o, 0);
    chk("reset done", done_o, 0);
    rst = 1'b0;
    // Pixels offered while idle must be ignored.
    pix_valid_i = 1'b1;
    pix_data_i  = 8'hee;
    repeat (3) tick();
    pix_valid_i = 1'b0;
    chk("idle busy", busy_o, 0);

    run_frame("t1", 3, 2, 0, 0, 8'h10, 0);
    run_frame("t2a", 16'h0104, 1, 0, 0, -1, 0);
    run_frame("t2b", 5, 0, 0, 0, -1, 0);
    run_frame("t3", 4, 4, 1, 1, 8'h20, 0);

    // Overflow: 20 pixels while the header is stalled; only 16 fit.
    tx_ready_i = 1'b0;
    push_header(5, 4);
    begin_frame(5, 4);
    for (int i = 0; i < 20; i++) begin
      pix_valid_i = 1'b1;
      pix_data_i  = 8'(8'h40 + i);
      if (i < FifoDepth) exp_q.push_back(8'(8'h40 + i));
      tick();
    end
    pix_valid_i = 1'b0;
    chk("t4 overflow_set", overflow_o, 1);
    chk("t4 stalled_valid", tx_valid_o, 1);
    chk("t4 stalled_data", tx_data_o, 8'h05);
    tx_ready_i = 1'b1;
    repeat (40) tick();
    chk("t4 partial_count", got.size(), 20);
    chk("t4 not_done", done_cnt, 0);
    chk("t4 still_busy", busy_o, 1);
    for (int i = 0; i < 4; i++) begin
      pix_valid_i = 1'b1;
      pix_data_i  = 8'(8'h60 + i);
      exp_q.push_back(8'(8'h60 + i));
      tick();
    end
    pix_valid_i = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 50 && !done_seen; i++) begin
      tick();
      if (done_o) done_seen = 1'b1;
    end
    tick();
    chk("t4 done_seen", done_seen, 1);
    check_stream("t4");
    chk("t4 overflow_sticky", overflow_o, 1);
    chk("t4 done_pulses", done_cnt, 1);

    run_frame("t5", 2, 2, 0, 0, 8'h30, 3);
    run_frame("t5b", 2, 1, 0, 0, 8'h50, 0);

    // Reset in the middle of the pixel phase.
    begin_frame(4, 1);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_valid_i = 1'b1;
      pix_data_i  = 8'(8'h90 + i);
      tick();
    end
    pix_valid_i = 1'b0;
    for (int i = 0; i < 100 && got.size() < 6; i++) tick();
    chk("t6 reached_pix", got.size(), 6);
    rst = 1'b1;
    tx_ready_i = 1'b0;
    tick();
    chk("t6 rst_valid", tx_valid_o, 0);
    chk("t6 rst_busy", busy_o, 0);
    rst = 1'b0;
    tick();
    run_frame("t6b", 1, 1, 0, 0, 8'h77, 0);

    for (int k = 0; k < 4; k++) begin
      run_frame($sformatf("rnd%0d", k), $urandom_range(1, 6), $urandom_range(1, 5), 2, 2, -1,
                $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
